// File: rtl/product_accumulator_128b.sv
// rtl/product_accumulator_128b.sv - groups 128-bit multiplier products into a sum, beat count and overflow flag.
// Optional macro ACC_SAT_EN: the group sum saturates at 2^128-1 instead of wrapping.
module product_accumulator_128b (
    input  logic         iClk,
    input  logic         iRst,
    input  logic         iEn,
    input  logic         iClr,
    input  logic         iValid,
    input  logic         iLast,
    input  logic [127:0] iData,
    output logic         oReady,
    output logic         oValid,
    input  logic         iReady,
    output logic [127:0] oData,
    output logic [15:0]  oCount,
    output logic         oOvf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q;
    logic [127:0]   sum_q;
    logic [15:0]    cnt_q;
    logic           ovf_q;
    logic           valid_q;
    logic [127:0]   data_q;
    logic [15:0]    count_q;
    logic           oovf_q;

    logic           beat;
    logic           xfer;
    logic           in_group;
    logic [127:0]   base_sum;
    logic [15:0]    base_cnt;
    logic [128:0]   add_w;
    logic           carry;
    logic [127:0]   sum_d;
    logic [15:0]    cnt_d;
    logic           ovf_d;

    assign oReady = !valid_q || iReady;
    assign oValid = valid_q;
    assign oData  = data_q;
    assign oCount = count_q;
    assign oOvf   = oovf_q;

    // Only ACC carries a live partial group; any other state starts a fresh one.
    always_comb begin
        beat     = iValid && oReady && iEn && !iClr;
        xfer     = valid_q && iReady && iEn;
        in_group = (state_q == ACC);
        base_sum = in_group ? sum_q : 128'd0;
        base_cnt = in_group ? cnt_q : 16'd0;
        add_w    = {1'b0, base_sum} + {1'b0, iData};
        carry    = add_w[128];
`ifdef ACC_SAT_EN
        sum_d    = carry ? {128{1'b1}} : add_w[127:0];
`else
        sum_d    = add_w[127:0];
`endif
        cnt_d    = (base_cnt == 16'hFFFF) ? 16'hFFFF : base_cnt + 16'd1;
        ovf_d    = (in_group && ovf_q) || carry;
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q <= IDLE;
            sum_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            count_q <= '0;
            oovf_q  <= 1'b0;
        end else if (iClr) begin
            state_q <= IDLE;
            sum_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            count_q <= '0;
            oovf_q  <= 1'b0;
        end else if (iEn) begin
            case (state_q)
                IDLE, ACC: begin
                    if (beat && iLast) begin
                        data_q  <= sum_d;
                        count_q <= cnt_d;
                        oovf_q  <= ovf_d;
                        valid_q <= 1'b1;
                        sum_q   <= '0;
                        cnt_q   <= '0;
                        ovf_q   <= 1'b0;
                        state_q <= DONE;
                    end else if (beat) begin
                        sum_q   <= sum_d;
                        cnt_q   <= cnt_d;
                        ovf_q   <= ovf_d;
                        state_q <= ACC;
                    end
                end
                DONE: begin
                    // A beat here implies oReady, so the held result leaves this cycle.
                    if (beat && iLast) begin
                        data_q  <= sum_d;
                        count_q <= cnt_d;
                        oovf_q  <= ovf_d;
                        valid_q <= 1'b1;
                        sum_q   <= '0;
                        cnt_q   <= '0;
                        ovf_q   <= 1'b0;
                        state_q <= DONE;
                    end else if (beat) begin
                        sum_q   <= sum_d;
                        cnt_q   <= cnt_d;
                        ovf_q   <= ovf_d;
                        valid_q <= 1'b0;
                        state_q <= ACC;
                    end else if (xfer) begin
                        valid_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_product_accumulator_128b.sv
// tb/tb_product_accumulator_128b.sv - scoreboard bench for product_accumulator_128b.
module tb_product_accumulator_128b;

    logic         iClk = 1'b0;
    logic         iRst;
    logic         iEn;
    logic         iClr;
    logic         iValid;
    logic         iLast;
    logic [127:0] iData;
    logic         oReady;
    logic         oValid;
    logic         iReady;
    logic [127:0] oData;
    logic [15:0]  oCount;
    logic         oOvf;

    typedef struct packed {
        logic [127:0] d;
        logic [15:0]  c;
        logic         o;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    product_accumulator_128b dut (
        .iClk   (iClk),
        .iRst   (iRst),
        .iEn    (iEn),
        .iClr   (iClr),
        .iValid (iValid),
        .iLast  (iLast),
        .iData  (iData),
        .oReady (oReady),
        .oValid (oValid),
        .iReady (iReady),
        .oData  (oData),
        .oCount (oCount),
        .oOvf   (oOvf)
    );

    always #5 iClk = ~iClk;

    // Every result transfer is matched against the oldest expected group.
    always @(negedge iClk) begin
        if (!iRst && !iClr && iEn && oValid && iReady) begin
            exp_t e;
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected: got data=%0h count=%0d ovf=%0b, expected no result", oData, oCount, oOvf);
            end else begin
                e = sb.pop_front();
                if (oData !== e.d || oCount !== e.c || oOvf !== e.o) begin
                    failures++;
                    $display("FAIL sb_result: got data=%0h count=%0d ovf=%0b, expected data=%0h count=%0d ovf=%0b",
                             oData, oCount, oOvf, e.d, e.c, e.o);
                end
            end
        end
    end

    task automatic cyc(input logic v, input logic last, input logic [127:0] d,
                       input logic rdy, input logic en, input logic clr);
        iValid = v;
        iLast  = last;
        iData  = d;
        iReady = rdy;
        iEn    = en;
        iClr   = clr;
        @(posedge iClk);
        #1;
    endtask

    task automatic push(input logic [127:0] d, input logic [15:0] c, input logic o);
        exp_t e;
        e.d = d;
        e.c = c;
        e.o = o;
        sb.push_back(e);
    endtask

    task automatic test_reset;
        iRst = 1'b1;
        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1, 0);
        checks++;
        if (oValid !== 1'b0 || oData !== 128'd0 || oCount !== 16'd0 || oOvf !== 1'b0 || oReady !== 1'b1) begin
            failures++;
            $display("FAIL reset_state: got valid=%0b data=%0h count=%0d ovf=%0b ready=%0b, expected 0/0/0/0/1",
                     oValid, oData, oCount, oOvf, oReady);
        end
        iRst = 1'b0;
        cyc(0, 0, 0, 0, 1, 0);
    endtask

    task automatic test_single;
        push(128'd5, 16'd1, 1'b0);
        cyc(1, 1, 128'd5, 0, 1, 0);
        checks++;
        if (oValid !== 1'b1 || oData !== 128'd5 || oCount !== 16'd1 || oOvf !== 1'b0) begin
            failures++;
            $display("FAIL single_beat: got valid=%0b data=%0h count=%0d ovf=%0b, expected 1/5/1/0",
                     oValid, oData, oCount, oOvf);
        end
        cyc(0, 0, 0, 1, 1, 0);
        checks++;
        if (oValid !== 1'b0) begin
            failures++;
            $display("FAIL single_drain: got valid=%0b, expected 0", oValid);
        end
    endtask

    task automatic test_back_to_back;
        cyc(1, 0, 128'd10, 1, 1, 0);
        cyc(1, 0, 128'd20, 1, 1, 0);
        push(128'd60, 16'd3, 1'b0);
        cyc(1, 1, 128'd30, 1, 1, 0);
        iValid = 1'b1; iLast = 1'b0; iData = 128'd40; iReady = 1'b1;
        #1;
        checks++;
        if (oValid !== 1'b1 || oReady !== 1'b1) begin
            failures++;
            $display("FAIL b2b_ready: got valid=%0b ready=%0b, expected 1/1", oValid, oReady);
        end
        cyc(1, 0, 128'd40, 1, 1, 0);
        push(128'd45, 16'd2, 1'b0);
        cyc(1, 1, 128'd5, 1, 1, 0);
        cyc(0, 0, 0, 1, 1, 0);
        checks++;
        if (oValid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_drain: got valid=%0b, expected 0", oValid);
        end
    endtask

    task automatic test_backpressure;
        push(128'd7, 16'd1, 1'b0);
        cyc(1, 1, 128'd7, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 1, 128'd99, 0, 1, 0);
            checks++;
            if (oReady !== 1'b0 || oValid !== 1'b1 || oData !== 128'd7 || oCount !== 16'd1) begin
                failures++;
                $display("FAIL bp_hold: got ready=%0b valid=%0b data=%0h count=%0d, expected 0/1/7/1",
                         oReady, oValid, oData, oCount);
            end
        end
        push(128'd99, 16'd1, 1'b0);
        cyc(1, 1, 128'd99, 1, 1, 0);
        checks++;
        if (oValid !== 1'b1 || oData !== 128'd99 || oCount !== 16'd1) begin
            failures++;
            $display("FAIL bp_accept: got valid=%0b data=%0h count=%0d, expected 1/99/1", oValid, oData, oCount);
        end
        cyc(0, 0, 0, 1, 1, 0);
    endtask

    task automatic test_overflow;
        logic [127:0] all_ones;
        all_ones = {128{1'b1}};
        cyc(1, 0, all_ones, 1, 1, 0);
`ifdef ACC_SAT_EN
        push(all_ones, 16'd2, 1'b1);
`else
        push(128'd1, 16'd2, 1'b1);
`endif
        cyc(1, 1, 128'd2, 0, 1, 0);
        checks++;
        if (oOvf !== 1'b1) begin
            failures++;
            $display("FAIL ovf_flag: got ovf=%0b, expected 1", oOvf);
        end
        cyc(0, 0, 0, 1, 1, 0);
        push(128'd3, 16'd1, 1'b0);
        cyc(1, 1, 128'd3, 0, 1, 0);
        checks++;
        if (oOvf !== 1'b0) begin
            failures++;
            $display("FAIL ovf_cleared: got ovf=%0b, expected 0", oOvf);
        end
        cyc(0, 0, 0, 1, 1, 0);
    endtask

    task automatic test_clear_enable;
        cyc(1, 0, 128'd3, 1, 1, 0);
        cyc(1, 0, 128'd4, 1, 1, 0);
        cyc(1, 1, 128'd100, 1, 1, 1);
        checks++;
        if (oValid !== 1'b0 || oData !== 128'd0) begin
            failures++;
            $display("FAIL clr_state: got valid=%0b data=%0h, expected 0/0", oValid, oData);
        end
        push(128'd7, 16'd1, 1'b0);
        cyc(1, 1, 128'd7, 1, 1, 0);
        cyc(0, 0, 0, 1, 1, 0);
        cyc(1, 0, 128'd10, 1, 1, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(1, 1, 128'd1000, 1, 0, 0);
            checks++;
            if (oValid !== 1'b0 || oReady !== 1'b1) begin
                failures++;
                $display("FAIL en_freeze: got valid=%0b ready=%0b, expected 0/1", oValid, oReady);
            end
        end
        push(128'd11, 16'd2, 1'b0);
        cyc(1, 1, 128'd1, 0, 1, 0);
        for (int i = 0; i < 2; i++) begin
            cyc(0, 0, 0, 1, 0, 0);
            checks++;
            if (oValid !== 1'b1 || oData !== 128'd11) begin
                failures++;
                $display("FAIL en_hold_result: got valid=%0b data=%0h, expected 1/11", oValid, oData);
            end
        end
        cyc(0, 0, 0, 1, 1, 0);
    endtask

    task automatic test_async_reset;
        cyc(1, 0, 128'd100, 0, 1, 0);
        cyc(1, 1, 128'd5, 0, 1, 0);
        #1;
        iRst = 1'b1;
        #1;
        checks++;
        if (oValid !== 1'b0 || oData !== 128'd0 || oCount !== 16'd0) begin
            failures++;
            $display("FAIL async_reset: got valid=%0b data=%0h count=%0d, expected 0/0/0", oValid, oData, oCount);
        end
        cyc(0, 0, 0, 0, 1, 0);
        iRst = 1'b0;
        push(128'd9, 16'd1, 1'b0);
        cyc(1, 1, 128'd9, 0, 1, 0);
        checks++;
        if (oValid !== 1'b1 || oData !== 128'd9 || oCount !== 16'd1) begin
            failures++;
            $display("FAIL post_reset: got valid=%0b data=%0h count=%0d, expected 1/9/1", oValid, oData, oCount);
        end
        cyc(0, 0, 0, 1, 1, 0);
    endtask

    initial begin
        iRst = 1'b1; iEn = 1'b0; iClr = 1'b0; iValid = 1'b0;
        iLast = 1'b0; iData = '0; iReady = 1'b0;
        #2;
        checks++;
        if (oValid !== 1'b0 || oData !== 128'd0) begin
            failures++;
            $display("FAIL reset_immediate: got valid=%0b data=%0h, expected 0/0", oValid, oData);
        end
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_overflow();
        test_clear_enable();
        test_async_reset();
        cyc(0, 0, 0, 1, 1, 0);
        cyc(0, 0, 0, 1, 1, 0);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover: got %0d pending results, expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
